// File: rtl/mem_access_seq_if.sv
// Signal bundle between the MEM-stage requester, the memory access sequencer and the memory.
interface mem_access_seq_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MAX_IND = 1
);
  localparam int unsigned IND_W = (MAX_IND < 2) ? 1 : $clog2(MAX_IND + 1);
  localparam int unsigned NB    = DATA_W / 8;

  logic              req_valid;
  logic              req_read;
  logic              req_write;
  logic              req_byte;
  logic [IND_W-1:0]  req_ind;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [NB-1:0]     mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  // Sequencer side.
  modport slave (
    input  req_valid, req_read, req_write, req_byte, req_ind, req_addr, req_wdata,
    input  mem_rdata, mem_resp,
    output busy, done, rdata,
    output mem_addr, mem_read, mem_write, mem_wmask, mem_wdata
  );

  // Requester / memory side.
  modport master (
    output req_valid, req_read, req_write, req_byte, req_ind, req_addr, req_wdata,
    output mem_rdata, mem_resp,
    input  busy, done, rdata,
    input  mem_addr, mem_read, mem_write, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_access_seq.sv
// MEM-stage access sequencer: optional pointer dereference chain followed by one
// word or byte load/store, stalling the pipeline until the memory responds.
module mem_access_seq #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MAX_IND = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_seq_if.slave  bus
);
  localparam int unsigned IND_W = (MAX_IND < 2) ? 1 : $clog2(MAX_IND + 1);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LB    = $clog2(NB);

  typedef enum logic [1:0] {IDLE, IND, ACCESS, DONE} state_e;

  state_e            state_q;
  logic [IND_W-1:0]  depth_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              write_q;
  logic              byte_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [NB-1:0]     mem_wmask_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              accept_c;
  logic [IND_W-1:0]  ind_clamp_c;
  logic [ADDR_W-1:0] ptr_next_c;
  logic [ADDR_W-1:0] fin_addr_c;
  logic              fin_byte_c;
  logic              fin_write_c;
  logic [DATA_W-1:0] fin_wdata_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [NB-1:0]     acc_mask_c;
  logic [DATA_W-1:0] acc_wdata_c;
  logic [DATA_W-1:0] lane_shift_c;

  assign accept_c   = (state_q == IDLE) && bus.req_valid && (bus.req_read || bus.req_write);
  assign ptr_next_c = ADDR_W'(bus.mem_rdata);

  // Depth requests beyond the supported chain length saturate.
  if (((2 ** IND_W) - 1) > MAX_IND) begin : g_clamp
    assign ind_clamp_c = (bus.req_ind > IND_W'(MAX_IND)) ? IND_W'(MAX_IND) : bus.req_ind;
  end else begin : g_noclamp
    assign ind_clamp_c = bus.req_ind;
  end

  // Final-access setup: from the live request when direct, from the last pointer otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      fin_addr_c  = bus.req_addr;
      fin_byte_c  = bus.req_byte;
      fin_write_c = bus.req_write;
      fin_wdata_c = bus.req_wdata;
    end else begin
      fin_addr_c  = ptr_next_c;
      fin_byte_c  = byte_q;
      fin_write_c = write_q;
      fin_wdata_c = wdata_q;
    end
    acc_addr_c  = fin_byte_c ? fin_addr_c : (fin_addr_c & ~ADDR_W'(NB - 1));
    acc_mask_c  = '0;
    acc_wdata_c = '0;
    if (fin_write_c) begin
      acc_mask_c  = fin_byte_c ? (NB'(1) << fin_addr_c[LB-1:0]) : '1;
      acc_wdata_c = fin_byte_c ? {NB{fin_wdata_c[7:0]}} : fin_wdata_c;
    end
  end

  assign lane_shift_c = bus.mem_rdata >> {ptr_q[LB-1:0], 3'b000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      ptr_q       <= '0;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            write_q <= bus.req_write;
            byte_q  <= bus.req_byte;
            wdata_q <= bus.req_wdata;
            ptr_q   <= bus.req_addr;
            depth_q <= ind_clamp_c;
            if (ind_clamp_c != '0) begin
              state_q    <= IND;
              mem_read_q <= 1'b1;
              mem_addr_q <= bus.req_addr;
            end else begin
              state_q     <= ACCESS;
              mem_read_q  <= !fin_write_c;
              mem_write_q <= fin_write_c;
              mem_addr_q  <= acc_addr_c;
              mem_wmask_q <= acc_mask_c;
              mem_wdata_q <= acc_wdata_c;
            end
          end
        end
        IND: begin
          if (bus.mem_resp) begin
            ptr_q   <= ptr_next_c;
            depth_q <= depth_q - IND_W'(1);
            if (depth_q == IND_W'(1)) begin
              state_q     <= ACCESS;
              mem_read_q  <= !fin_write_c;
              mem_write_q <= fin_write_c;
              mem_addr_q  <= acc_addr_c;
              mem_wmask_q <= acc_mask_c;
              mem_wdata_q <= acc_wdata_c;
            end else begin
              mem_addr_q <= ptr_next_c;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_resp) begin
            if (!write_q) begin
              rdata_q <= byte_q ? DATA_W'(lane_shift_c[7:0]) : bus.mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle combinationally so the pipeline freezes immediately.
  assign bus.busy      = (state_q == IND) || (state_q == ACCESS) || accept_c;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// Randomized bench for mem_access_seq: a reference model computes the expected memory
// access sequence, latency and load result; a responder serves memory with random waits.
module tb_mem_access_seq;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned MAX_IND = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  mask;
    logic [15:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_IND(MAX_IND)) bus ();
  mem_access_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_IND(MAX_IND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_access = 0;
  acc_t exp_q[$];
  int   wait_q[$];
  logic [15:0] ref_mem [int];
  logic [15:0] phys_mem [int];
  logic [15:0] exp_rdata = '0;
  logic stray_resp = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [15:0] dflt(input int idx);
    return 16'((idx * 40503) ^ 23130);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    int idx = int'(a >> 1);
    return ref_mem.exists(idx) ? ref_mem[idx] : dflt(idx);
  endfunction

  function automatic logic [15:0] phys_rd(input logic [15:0] a);
    int idx = int'(a >> 1);
    return phys_mem.exists(idx) ? phys_mem[idx] : dflt(idx);
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    ref_mem[int'(a >> 1)]  = d;
    phys_mem[int'(a >> 1)] = d;
  endtask

  // Memory responder: one access per strobe episode, random wait then a one-cycle resp.
  initial begin
    acc_t cur, rec;
    logic [15:0] w;
    int wait_left;
    logic pending;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    pending = 1'b0;
    wait_left = 0;
    rec = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp = 1'b0;
      if (stray_resp) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'($urandom);
        stray_resp    = 1'b0;
      end else if (!reset && (bus.mem_read || bus.mem_write)) begin
        cur = '{addr: bus.mem_addr, rd: bus.mem_read, wr: bus.mem_write,
                mask: bus.mem_wmask, wdata: bus.mem_wdata};
        if (!pending) begin
          pending = 1'b1;
          rec = cur;
          n_access++;
          wait_left = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
          if (exp_q.size() == 0) check("extra_access", 64'(cur), 64'(0));
          else check("access", 64'(cur), 64'(exp_q.pop_front()));
        end else begin
          check("stable", 64'(cur), 64'(rec));
        end
        if (wait_left == 0) begin
          bus.mem_resp = 1'b1;
          w = phys_rd(cur.addr);
          bus.mem_rdata = w;
          if (cur.wr) begin
            if (cur.mask[0]) w[7:0]  = cur.wdata[7:0];
            if (cur.mask[1]) w[15:8] = cur.wdata[15:8];
            phys_mem[int'(cur.addr >> 1)] = w;
          end
          pending = 1'b0;
        end else begin
          wait_left--;
        end
      end else begin
        pending = 1'b0;
      end
    end
  end

  // One request through the model and the DUT; waits drawn from [wmin, wmax] per access.
  task automatic run_req(input logic rd, input logic wr, input logic byt, input logic [1:0] ind,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int wmin, input int wmax);
    int depth, wsum, lat, w, busy_n, done_n, done_at;
    logic [15:0] p, word;
    depth = (int'(ind) > MAX_IND) ? MAX_IND : int'(ind);
    p = addr;
    for (int i = 0; i < depth; i++) begin
      exp_q.push_back('{addr: p, rd: 1'b1, wr: 1'b0, mask: 2'b00, wdata: 16'h0});
      p = ref_rd(p);
    end
    word = ref_rd(p);
    if (wr) begin
      if (byt) begin
        exp_q.push_back('{addr: p, rd: 1'b0, wr: 1'b1, mask: (p[0] ? 2'b10 : 2'b01),
                          wdata: {wdata[7:0], wdata[7:0]}});
        ref_mem[int'(p >> 1)] = p[0] ? {wdata[7:0], word[7:0]} : {word[15:8], wdata[7:0]};
      end else begin
        exp_q.push_back('{addr: {p[15:1], 1'b0}, rd: 1'b0, wr: 1'b1, mask: 2'b11, wdata: wdata});
        ref_mem[int'(p >> 1)] = wdata;
      end
    end else begin
      exp_q.push_back('{addr: (byt ? p : {p[15:1], 1'b0}), rd: 1'b1, wr: 1'b0,
                        mask: 2'b00, wdata: 16'h0});
      exp_rdata = byt ? 16'((word >> (8 * int'(p[0]))) & 16'h00FF) : word;
    end
    wsum = 0;
    for (int i = 0; i <= depth; i++) begin
      w = $urandom_range(wmax, wmin);
      wait_q.push_back(w);
      wsum += w;
    end
    lat = 2 + depth + wsum;

    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.req_byte  = byt;
    bus.req_ind   = ind;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    busy_n = 0;
    done_n = 0;
    done_at = -1;
    for (int k = 0; k < lat + 3; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      @(posedge clk); #1;
      if (k == done_at) begin
        bus.req_valid = 1'b0;
      end else if (done_at < 0) begin
        bus.req_read  = 1'($urandom);
        bus.req_write = 1'b1;
        bus.req_byte  = 1'($urandom);
        bus.req_ind   = 2'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
      end
    end
    bus.req_valid = 1'b0;
    check("done_cycle", 64'(done_at), 64'(lat));
    check("done_pulses", 64'(done_n), 64'(1));
    check("busy_cycles", 64'(busy_n), 64'(lat));
    check("rdata", 64'(bus.rdata), 64'(exp_rdata));
    check("pending_accesses", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    wait_q.delete();
  endtask

  initial begin
    int acc_before;
    int op;
    bus.req_valid = 1'b0;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_ind   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_mem_read", 64'(bus.mem_read), 64'(0));
    check("rst_mem_write", 64'(bus.mem_write), 64'(0));
    check("rst_mem_wmask", 64'(bus.mem_wmask), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    check("rst_rdata", 64'(bus.rdata), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Word load, byte store, single indirection, then indirect store under long waits.
    preload(16'h1234, 16'hBEEF);
    run_req(1'b1, 1'b0, 1'b0, 2'd0, 16'h1235, 16'h0000, 0, 0);
    run_req(1'b0, 1'b1, 1'b1, 2'd0, 16'h2001, 16'h00A5, 0, 0);
    preload(16'h3000, 16'h4002);
    preload(16'h4002, 16'h1111);
    run_req(1'b1, 1'b0, 1'b0, 2'd1, 16'h3000, 16'h0000, 0, 0);
    preload(16'h6000, 16'h7003);
    run_req(1'b0, 1'b1, 1'b0, 2'd1, 16'h6000, 16'h1357, 3, 3);
    run_req(1'b1, 1'b0, 1'b0, 2'd0, 16'h7002, 16'h0000, 0, 1);
    run_req(1'b1, 1'b0, 1'b1, 2'd0, 16'h2001, 16'h0000, 1, 2);
    run_req(1'b1, 1'b1, 1'b0, 2'd3, 16'h3000, 16'hCAFE, 0, 2);

    // No-op request must not stall, pulse done or touch memory.
    acc_before = n_access;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("noop_busy", 64'(bus.busy), 64'(0));
      check("noop_done", 64'(bus.done), 64'(0));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("noop_access", 64'(n_access), 64'(acc_before));

    // Reset during a long-wait load, then a stray response.
    exp_q.push_back('{addr: 16'h5000, rd: 1'b1, wr: 1'b0, mask: 2'b00, wdata: 16'h0});
    wait_q.push_back(8);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_read  = 1'b1;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_ind   = '0;
    bus.req_addr  = 16'h5001;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_read", 64'(bus.mem_read), 64'(1));
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("mid_rst_read", 64'(bus.mem_read), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_addr", 64'(bus.mem_addr), 64'(0));
    check("mid_rst_rdata", 64'(bus.rdata), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    stray_resp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_done", 64'(bus.done), 64'(0));
      check("post_rst_read", 64'(bus.mem_read), 64'(0));
    end
    exp_q.delete();
    wait_q.delete();
    exp_rdata = '0;
    run_req(1'b1, 1'b0, 1'b0, 2'd0, 16'h1235, 16'h0000, 0, 0);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(3, 0);
      run_req((op == 0) || (op == 2) || (op == 3), (op == 1) || (op == 2), 1'($urandom),
              2'($urandom), 16'($urandom), 16'($urandom), 0, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 Parameter DATA_W, default 16, memory data width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter MAX_IND, default 1, maximum pointer-dereference depth (0..3); IND_W = max(1, clog2(MAX_IND+1)).
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  MEM-stage request present (control word valid).
REQ-007 req_read  input  1  load access (mem_read bit of control word).
REQ-008 req_write  input  1  store access (mem_write bit).
REQ-009 req_byte  input  1  byte-sized access (in_byte).
REQ-010 req_ind  input  IND_W  number of pointer reads before the final access (0 = direct).
REQ-011 req_addr  input  ADDR_W  effective byte address.
REQ-012 req_wdata  input  DATA_W  store data; byte mode uses bits [7:0].
REQ-013 busy  output  1  stall request to upstream pipeline enables.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 rdata  output  DATA_W  load result; byte loads zero-extended.
REQ-016 mem_addr  output  ADDR_W  memory byte address.
REQ-017 mem_read / mem_write  output  1 each  memory strobes.
REQ-018 mem_wmask  output  DATA_W/8  byte-lane write enables.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_rdata  input  DATA_W  memory read data, valid with mem_resp.
REQ-021 mem_resp  input  1  memory completion, one cycle per access.

Function
REQ-022 FSM states SHALL be IDLE, IND, ACCESS, DONE.
REQ-023 IDLE: req_valid & (req_read|req_write) SHALL capture request into registers and go IND if req_ind≠0 (or req_ind>MAX_IND, clamped to MAX_IND), else ACCESS.
REQ-024 A request with req_read=req_write=0 SHALL be ignored: no busy, no done, no memory strobe.
REQ-025 req_read & req_write both set SHALL be treated as write (final access), reads only for pointers.
REQ-026 IND: mem_read=1, mem_addr=current pointer; on mem_resp, pointer <= mem_rdata[ADDR_W-1:0], depth decrements; depth reaching 0 SHALL go ACCESS, else stay IND.
REQ-027 ACCESS: exactly one of mem_read/mem_write asserted, held stable until mem_resp.
REQ-028 Word access: mem_addr low LB=clog2(DATA_W/8) bits forced 0, mem_wmask all ones, mem_wdata=req_wdata.
REQ-029 Byte access: lane = addr[LB-1:0]; mem_wmask one-hot at lane; mem_wdata = byte replicated across all lanes; mem_addr passed unmodified.
REQ-030 ACCESS on mem_resp: read SHALL latch rdata (word, or selected lane zero-extended); write leaves rdata unchanged; go DONE.
REQ-031 DONE: done=1 for exactly one cycle, busy=0, strobes 0; req_valid ignored; next state IDLE.
REQ-032 busy SHALL be 1 in IND and ACCESS, and combinationally 1 in IDLE when an accepted request (REQ-023) is present; 0 otherwise.
REQ-033 mem_resp in IDLE or DONE SHALL be ignored.
REQ-034 Latency with zero-wait memory: direct access done 2 cycles after acceptance; each indirection adds 1 cycle.
REQ-035 Captured request SHALL NOT change while busy, regardless of input changes.

Reset
REQ-036 reset SHALL asynchronously force IDLE; busy, done, mem_read, mem_write, mem_wmask, mem_addr, mem_wdata, rdata all 0.
REQ-037 Reset mid-IND/ACCESS SHALL drop strobes immediately, abandon the request, never pulse done; a later mem_resp is ignored.

Verification
REQ-038 Word LDR: addr=0x1235, read, mem_rdata=0xBEEF, resp 1 cycle later -> mem_addr=0x1234, rdata=0xBEEF, done one pulse, busy 2 cycles.
REQ-039 STB: addr=0x2001, wdata=0x00A5 -> mem_wmask=2'b10, mem_wdata=0xA5A5, mem_write until resp, rdata unchanged.
REQ-040 LDI: req_ind=1, addr=0x3000, pointer 0x4002, data 0x1111 -> read 0x3000, then read 0x4002, rdata=0x1111.
REQ-041 STI with 3-cycle memory waits: strobes/address stable across waits; write to pointer address; done after final resp only.
REQ-042 Reset asserted during ACCESS, then stray mem_resp -> outputs 0, no done, next request served normally.
REQ-043 req_valid with read=write=0, and req_valid held high during DONE -> no busy, no extra access or done.
